dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Two-port arbiter and sequencer in front of the byte-addressed data memory.
- Requester 0 is the core load/store path; requester 1 is the loader/debug port.
- Arbitrates round-robin, drives the memory's address, write-lane enables and byte write data, and formats load data (sign/zero extension).
- Returns a registered per-port response with an error flag for illegal or misaligned accesses.

Parameters:
- ADDRESS_WIDTH, 32, memory byte-address width.
- DATA_WIDTH, 32, requester data width; fixed at 32 (four byte lanes).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- pN_req  in  1  request; for N in {0,1}, each port has its own set of pN_ signals.
- pN_we  in  1  1 = store, 0 = load.
- pN_funct3  in  3  RISC-V width code: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
- pN_addr  in  ADDRESS_WIDTH  byte address.
- pN_wdata  in  DATA_WIDTH  store data, right-aligned.
- pN_gnt  out  1  one-cycle pulse; request fields sampled at this posedge.
- pN_rvalid  out  1  one-cycle completion pulse (loads and stores).
- pN_err  out  1  qualifies pN_rvalid; the access was not performed.
- pN_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- mem_re  out  3  memory read mode; 3'b111 (full word) whenever a load is in ACCESS, else 3'b000.
- mem_we  out  4  per-lane write enables.
- mem_a  out  ADDRESS_WIDTH  memory byte address.
- mem_wd1..mem_wd4  out  8 each  lane write data, mem_wd1 = byte at mem_a.
- mem_rd  in  DATA_WIDTH  combinational memory read data, lane 0 = byte at mem_a.

Behaviour:
- FSM with two states: IDLE and ACCESS. Reset to IDLE.
- Priority pointer last_gnt resets to 1, so port 0 wins the first tie.
- IDLE:
  - If exactly one port requests, that port is granted.
  - If both request, the port != last_gnt is granted.
  - On a grant: pN_gnt=1 combinationally in that cycle; at the posedge, latch we/funct3/addr/wdata and the port id, update last_gnt, and go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS (exactly one cycle, always followed by IDLE):
  - mem_a = latched addr.
  - Stores: mem_we = 0001 (byte), 0011 (half), 1111 (word); mem_wdK = wdata[8K-1:8K-8]. The write commits at the posedge ending ACCESS.
  - Loads: mem_re=111, mem_we=0000. At the posedge, rdata is captured from mem_rd with extension:
    - byte: sign-extend bit 7 (000) or zero-extend (100);
    - half: sign-extend bit 15 (001) or zero-extend (101);
    - word (010): no extension.
- Response: pN_rvalid is high for exactly the cycle after ACCESS, for the owning port only. pN_rdata/pN_err are registered and hold until the next response to that port.
- Throughput: one access per 2 cycles. A grant in IDLE may coincide with the previous access's rvalid.
- Errors: illegal funct3 is any of 011, 110, 111, or 100/101 with we=1. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0. On either:
  - ACCESS still occupies one cycle, but mem_we=0000 and mem_re=000;
  - the response has err=1, rdata=0.
- Outside ACCESS: mem_we=0000, mem_re=000, mem_a holds its last value.
- A requester must hold pN_req and its fields stable until pN_gnt. Deasserting pN_req before the grant withdraws the request without error.
- Address wrap: no check; mem_a is passed through modulo 2^ADDRESS_WIDTH.
- Reset (asynchronous, any state, including mid-ACCESS):
  - FSM goes to IDLE; mem_we=0000 immediately, so no write commits at the next edge.
  - gnt, rvalid, err, rdata, mem_a, latched fields all go to 0; last_gnt goes to 1.
  - An in-flight access produces no response.

Decomposition:
- Package dmem_ctrl_pkg: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), FSM state enum, lane-enable constants (WE_B, WE_H, WE_W).
- One natural sub-module, dmem_load_fmt: combinational funct3 + 32-bit raw data -> extended 32-bit result. Unit-testable on its own.

Test Plan:
- Word store/load: p0 sw addr 0x100 data 0xDEADBEEF -> gnt in cycle 0, mem_we=1111 and wd1..4 = EF,BE,AD,DE in cycle 1, rvalid in cycle 2. Then p0 lw 0x100 -> rdata 0xDEADBEEF, err=0.
- Extension: memory byte at 0x104 = 0x80 -> lb gives 0xFFFFFF80, lbu gives 0x00000080. Half at 0x106 = 0x8001 -> lh gives 0xFFFF8001, lhu gives 0x00008001.
- Arbitration: both ports request continuously from reset -> grants alternate p0, p1, p0, p1 every 2 cycles. Each rvalid reaches only the owning port.
- Errors: lw addr 0x102 -> err=1, rdata=0, mem_we stays 0000. sb with funct3=100 -> err=1. funct3=011 load -> err=1. Memory contents unchanged in all three cases.
- Reset mid-op: assert rst during the ACCESS cycle of sw 0x200 = 0x12345678 -> word at 0x200 keeps its old value, no rvalid. After release, the first contended grant goes to p0.
- Sub-word store: sh 0x300 data 0xAAAA1234 over initial 0xFFFFFFFF -> mem_we=0011; a following lw 0x300 reads 0xFFFF1234.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared funct3 codes, FSM states and lane-enable constants.
package dmem_ctrl_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [3:0] WE_B = 4'b0001;
  localparam logic [3:0] WE_H = 4'b0011;
  localparam logic [3:0] WE_W = 4'b1111;
  typedef enum logic {S_IDLE, S_ACCESS} state_t;
  function automatic logic [3:0] lane_en(input logic [1:0] size);
    return size == 2'b00 ? WE_B : size == 2'b01 ? WE_H : WE_W;
  endfunction
  // Illegal code (reserved widths, or unsigned widths used for a store) or misaligned address.
  function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic illegal, misaligned;
    illegal    = f3 == 3'b011 || f3[2:1] == 2'b11 || (f3[2] && we);
    misaligned = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
    return illegal || misaligned;
  endfunction
endpackage

// File: rtl/dmem_load_fmt.sv
// dmem_load_fmt: extends raw memory read data to a 32-bit load result by funct3.
module dmem_load_fmt
  import dmem_ctrl_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_raw,
  output logic [31:0] o_data
);
  always_comb
    o_data = i_funct3 == F3_B  ? {{24{i_raw[7]}}, i_raw[7:0]} :
             i_funct3 == F3_BU ? {24'd0, i_raw[7:0]} :
             i_funct3 == F3_H  ? {{16{i_raw[15]}}, i_raw[15:0]} :
             i_funct3 == F3_HU ? {16'd0, i_raw[15:0]} : i_raw;
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: round-robin two-port arbiter and one-cycle access sequencer for the data memory.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     p0_req,
  input  logic                     p0_we,
  input  logic [2:0]               p0_funct3,
  input  logic [ADDRESS_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0]    p0_wdata,
  output logic                     p0_gnt,
  output logic                     p0_rvalid,
  output logic                     p0_err,
  output logic [DATA_WIDTH-1:0]    p0_rdata,
  input  logic                     p1_req,
  input  logic                     p1_we,
  input  logic [2:0]               p1_funct3,
  input  logic [ADDRESS_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0]    p1_wdata,
  output logic                     p1_gnt,
  output logic                     p1_rvalid,
  output logic                     p1_err,
  output logic [DATA_WIDTH-1:0]    p1_rdata,
  output logic [2:0]               mem_re,
  output logic [3:0]               mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [7:0]               mem_wd1,
  output logic [7:0]               mem_wd2,
  output logic [7:0]               mem_wd3,
  output logic [7:0]               mem_wd4,
  input  logic [DATA_WIDTH-1:0]    mem_rd
);
  state_t                   r_state;
  logic                     r_last, r_port, r_we;
  logic [2:0]               r_f3;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic                     w_acc, w_g0, w_g1, w_err;
  logic [DATA_WIDTH-1:0]    w_ld, w_rsp;
  assign w_acc  = r_state == S_ACCESS;
  // On a tie the port that did not win last time is granted.
  assign w_g0   = !w_acc && p0_req && (!p1_req || r_last);
  assign w_g1   = !w_acc && p1_req && (!p0_req || !r_last);
  assign p0_gnt = w_g0;
  assign p1_gnt = w_g1;
  assign w_err  = access_err(r_we, r_f3, r_addr[1:0]);
  assign mem_a  = r_addr;
  assign mem_we = (w_acc && r_we && !w_err) ? lane_en(r_f3[1:0]) : 4'b0000;
  assign mem_re = (w_acc && !r_we && !w_err) ? 3'b111 : 3'b000;
  assign {mem_wd4, mem_wd3, mem_wd2, mem_wd1} = r_wdata;
  assign w_rsp  = (r_we || w_err) ? '0 : w_ld;
  dmem_load_fmt u_fmt (.i_funct3(r_f3), .i_raw(mem_rd), .o_data(w_ld));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_port    <= 1'b0;
      r_we      <= 1'b0;
      r_f3      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      p0_rvalid <= 1'b0;
      p0_err    <= 1'b0;
      p0_rdata  <= '0;
      p1_rvalid <= 1'b0;
      p1_err    <= 1'b0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_g0 || w_g1) begin
          r_state <= S_ACCESS;
          r_port  <= w_g1;
          r_last  <= w_g1;
          r_we    <= w_g1 ? p1_we : p0_we;
          r_f3    <= w_g1 ? p1_funct3 : p0_funct3;
          r_addr  <= w_g1 ? p1_addr : p0_addr;
          r_wdata <= w_g1 ? p1_wdata : p0_wdata;
        end
      end else begin
        r_state <= S_IDLE;
        if (r_port) begin
          p1_rvalid <= 1'b1;
          p1_err    <= w_err;
          p1_rdata  <= w_rsp;
        end else begin
          p0_rvalid <= 1'b1;
          p0_err    <= w_err;
          p0_rdata  <= w_rsp;
        end
      end
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scoreboard bench with a byte-array memory, reference model and random traffic.
module tb_dmem_ctrl;
  logic clk = 0, rst = 1;
  logic [1:0] req = 0, we = 0;
  logic [2:0] f3 [2];
  logic [31:0] ad [2], wd [2];
  logic p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata, mem_a, mem_rd;
  logic [2:0] mem_re;
  logic [3:0] mem_we;
  logic [7:0] mem_wd1, mem_wd2, mem_wd3, mem_wd4;
  logic [1:0] gnt;
  logic [7:0] mem [4096];
  logic [7:0] rmem [4096];
  typedef struct {logic [31:0] d; logic e; int due;} rsp_t;
  rsp_t q [2][$];
  int checks = 0, errors = 0, cyc = 0;
  logic m_acc = 0, m_last = 1;
  logic [3:0] m_we;
  logic [2:0] m_re;
  logic [31:0] m_addr, m_wd;

  always #5 clk = ~clk;
  assign gnt = {p1_gnt, p0_gnt};

  dmem_ctrl dut (
    .clk(clk), .rst(rst),
    .p0_req(req[0]), .p0_we(we[0]), .p0_funct3(f3[0]), .p0_addr(ad[0]), .p0_wdata(wd[0]),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(req[1]), .p1_we(we[1]), .p1_funct3(f3[1]), .p1_addr(ad[1]), .p1_wdata(wd[1]),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_a(mem_a),
    .mem_wd1(mem_wd1), .mem_wd2(mem_wd2), .mem_wd3(mem_wd3), .mem_wd4(mem_wd4),
    .mem_rd(mem_rd));

  assign mem_rd = {mem[12'(mem_a[11:0] + 12'd3)], mem[12'(mem_a[11:0] + 12'd2)],
                   mem[12'(mem_a[11:0] + 12'd1)], mem[mem_a[11:0]]};
  always @(posedge clk) begin
    if (mem_we[0]) mem[mem_a[11:0]] <= mem_wd1;
    if (mem_we[1]) mem[12'(mem_a[11:0] + 12'd1)] <= mem_wd2;
    if (mem_we[2]) mem[12'(mem_a[11:0] + 12'd2)] <= mem_wd3;
    if (mem_we[3]) mem[12'(mem_a[11:0] + 12'd3)] <= mem_wd4;
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", n, cyc, act, exp);
    end
  endtask

  // Reference: decode width/signedness from the RISC-V code, then do the access on rmem.
  task automatic model_access(input int p);
    int nb;
    logic sgn, uns, err;
    logic [31:0] a, v, msk;
    rsp_t r;
    a = ad[p];
    nb = 0; sgn = 1; uns = 0;
    case (f3[p])
      3'd0: nb = 1;
      3'd1: nb = 2;
      3'd2: nb = 4;
      3'd4: begin nb = 1; sgn = 0; uns = 1; end
      3'd5: begin nb = 2; sgn = 0; uns = 1; end
      default: nb = 0;
    endcase
    err = nb == 0 || (we[p] && uns) || (a % nb != 0);
    v = 0;
    if (!err)
      for (int k = 0; k < nb; k++) v |= 32'(rmem[12'(a[11:0] + 12'(k))]) << (8 * k);
    msk = nb == 4 ? 32'hFFFFFFFF : (32'd1 << (8 * nb)) - 1;
    if (!err && sgn && nb < 4 && v[8 * nb - 1]) v |= ~msk;
    m_we = (err || !we[p]) ? 4'd0 : 4'((1 << nb) - 1);
    m_re = (err || we[p]) ? 3'd0 : 3'b111;
    m_addr = a;
    m_wd = wd[p];
    r.d = (err || we[p]) ? 32'd0 : v;
    r.e = err;
    r.due = cyc + 2;
    q[p].push_back(r);
    m_acc = 1;
    m_last = p[0];
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q[0].delete();
      q[1].delete();
      m_acc = 0;
      m_last = 1;
      chk("rst_ctrl", {16'd0, gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_we, mem_re, 3'd0}, 0);
      chk("rst_mem_a", mem_a, 0);
      chk("rst_rdata", p0_rdata | p1_rdata, 0);
    end else begin
      for (int p = 0; p < 2; p++) begin
        logic rv;
        rsp_t e;
        rv = p == 0 ? p0_rvalid : p1_rvalid;
        if (rv) begin
          if (q[p].size() == 0) chk($sformatf("rvalid_unexpected_p%0d", p), 32'(rv), 0);
          else begin
            e = q[p].pop_front();
            chk($sformatf("rdata_p%0d", p), p == 0 ? p0_rdata : p1_rdata, e.d);
            chk($sformatf("err_p%0d", p), 32'(p == 0 ? p0_err : p1_err), 32'(e.e));
            chk($sformatf("rvalid_cycle_p%0d", p), cyc, e.due);
          end
        end else if (q[p].size() != 0 && q[p][0].due <= cyc) begin
          chk($sformatf("rvalid_missing_p%0d", p), 32'(rv), 1);
          void'(q[p].pop_front());
        end
      end
      if (m_acc) begin
        chk("gnt_in_access", 32'(gnt), 0);
        chk("mem_we", 32'(mem_we), 32'(m_we));
        chk("mem_re", 32'(mem_re), 32'(m_re));
        chk("mem_a", mem_a, m_addr);
        if (m_we != 0) chk("mem_wd", {mem_wd4, mem_wd3, mem_wd2, mem_wd1}, m_wd);
        for (int k = 0; k < 4; k++)
          if (m_we[k]) rmem[12'(m_addr[11:0] + 12'(k))] = m_wd[8*k +: 8];
        m_acc = 0;
      end else begin
        logic [1:0] eg;
        eg = (req == 2'b11) ? (m_last ? 2'b01 : 2'b10) : req;
        chk("gnt", 32'(gnt), 32'(eg));
        if (eg != 0) model_access(eg[1] ? 1 : 0);
      end
    end
  end

  task automatic issue(input int p, input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d);
    bit ok = 0;
    we[p] = w; f3[p] = f; ad[p] = a; wd[p] = d; req[p] = 1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = gnt[p];
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL grant_timeout_p%0d: got no gnt in 40 cycles, expected gnt", p);
    end
    @(posedge clk);
    #1 req[p] = 0;
  endtask

  task automatic rand_port(input int p, input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      a = $urandom_range(0, 1023) * 4;
      if ($urandom_range(0, 3) == 0) a += $urandom_range(0, 3);
      issue(p, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end
  endtask

  initial begin
    int bad;
    f3[0] = 0; f3[1] = 0; ad[0] = 0; ad[1] = 0; wd[0] = 0; wd[1] = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3);
    mem['h104] = 8'h80; mem['h106] = 8'h01; mem['h107] = 8'h80;
    for (int i = 0; i < 4; i++) mem['h300 + i] = 8'hFF;
    for (int i = 0; i < 4; i++) mem['h200 + i] = 8'(8'h11 * (i + 1));
    for (int i = 0; i < 4096; i++) rmem[i] = mem[i];
    repeat (3) @(posedge clk);
    #1 rst = 0;
    fork
      for (int i = 0; i < 4; i++) issue(0, 0, 3'b010, 32'(i * 4), 0);
      for (int i = 0; i < 4; i++) issue(1, 0, 3'b010, 32'(64 + i * 4), 0);
    join
    issue(0, 1, 3'b010, 32'h100, 32'hDEADBEEF);
    issue(0, 0, 3'b010, 32'h100, 0);
    issue(0, 0, 3'b000, 32'h104, 0);
    issue(0, 0, 3'b100, 32'h104, 0);
    issue(0, 0, 3'b001, 32'h106, 0);
    issue(0, 0, 3'b101, 32'h106, 0);
    issue(0, 0, 3'b010, 32'h102, 0);
    issue(0, 1, 3'b100, 32'h110, 32'h55);
    issue(0, 0, 3'b011, 32'h120, 0);
    issue(1, 1, 3'b001, 32'h300, 32'hAAAA1234);
    issue(1, 0, 3'b010, 32'h300, 0);
    issue(0, 1, 3'b010, 32'h200, 32'h12345678);
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    fork
      issue(0, 0, 3'b010, 32'h200, 0);
      issue(1, 0, 3'b010, 32'h200, 0);
    join
    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join
    repeat (5) @(negedge clk);
    chk("drain_p0", q[0].size(), 0);
    chk("drain_p1", q[1].size(), 0);
    bad = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== rmem[i]) bad++;
    chk("mem_image_bad_bytes", bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
